// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion,
// redirect flush, downstream hold and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int XLEN = 32,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid_i,
  input  logic [6:0]      id_opcode_i,
  input  logic [2:0]      id_func3_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [18:0]     id_ctrl_i,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            load_use_stall_o,
  output logic            ex_valid_o,
  output logic [18:0]     ex_ctrl_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [CNTW-1:0] bubble_count_o
);

  localparam int MEMTOREG = 10;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic [18:0]     ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } id_ex_t;

  id_ex_t          ex_d, ex_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            uses_rs1, uses_rs2;
  logic            hit_rs1, hit_rs2;
  logic            stall;

  // func3 already travels inside the control bundle
  logic unused_func3;
  assign unused_func3 = ^id_func3_i;

  // Operand-use decode and load-use hazard detect
  always_comb begin
    uses_rs1 = !(id_opcode_i == OP_LUI ||
                 id_opcode_i == OP_AUIPC ||
                 id_opcode_i == OP_JAL);
    uses_rs2 = (id_opcode_i == OP_R ||
                id_opcode_i == OP_STORE ||
                id_opcode_i == OP_BR);
    hit_rs1  = uses_rs1 && (ex_q.rd == id_rs1_i);
    hit_rs2  = uses_rs2 && (ex_q.rd == id_rs2_i);
    stall    = id_valid_i && ex_q.valid &&
               ex_q.ctrl[MEMTOREG] &&
               (ex_q.rd != 5'd0) &&
               (hit_rs1 || hit_rs2) &&
               !flush_i && !hold_i;
  end

  // Next-state: flush > hold > bubble > capture
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (hold_i) begin
      ex_d = ex_q;
    end else if (stall) begin
      ex_d = '0;
      if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end else begin
      ex_d.valid    = id_valid_i;
      ex_d.ctrl     = id_valid_i ? id_ctrl_i : '0;
      ex_d.pc       = id_pc_i;
      ex_d.rs1_data = id_rs1_data_i;
      ex_d.rs2_data = id_rs2_data_i;
      ex_d.imm      = id_imm_i;
      ex_d.rs1      = id_rs1_i;
      ex_d.rs2      = id_rs2_i;
      ex_d.rd       = id_rd_i;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign load_use_stall_o = stall;
  assign ex_valid_o       = ex_q.valid;
  assign ex_ctrl_o        = ex_q.ctrl;
  assign ex_pc_o          = ex_q.pc;
  assign ex_rs1_data_o    = ex_q.rs1_data;
  assign ex_rs2_data_o    = ex_q.rs2_data;
  assign ex_imm_o         = ex_q.imm;
  assign ex_rs1_o         = ex_q.rs1;
  assign ex_rs2_o         = ex_q.rs2;
  assign ex_rd_o          = ex_q.rd;
  assign bubble_count_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: scoreboard of expected
// EX contents, one entry per clock edge.
module tb_id_ex_stage_reg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  // {alu_src,mw,lt[2:0],st[1:0],wb,m2r,br,jal,jalr,alu[3:0],f3[2:0]}
  localparam logic [18:0] CT_LOAD  = 19'b1_0_010_00_1_1_0_0_0_0000_010;
  localparam logic [18:0] CT_ADD   = 19'b0_0_000_00_1_0_0_0_0_0000_000;
  localparam logic [18:0] CT_LUI   = 19'b1_0_000_00_1_0_0_0_0_1010_000;
  localparam logic [18:0] CT_STORE = 19'b1_1_000_10_0_0_0_0_0_0000_010;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [2:0]  id_func3;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [18:0] id_ctrl;
  logic        flush, hold;

  logic        stall, ex_valid;
  logic [18:0] ex_ctrl;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] cnt;

  logic        stall4, ex_valid4;
  logic [18:0] ex_ctrl4;
  logic [31:0] ex_pc4, ex_rs1_data4, ex_rs2_data4, ex_imm4;
  logic [4:0]  ex_rs14, ex_rs24, ex_rd4;
  logic [3:0]  cnt4;

  typedef struct {
    logic        v;
    logic [18:0] ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
    int          nb;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   nb    = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32), .CNTW(32)) u_dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_opcode_i(id_opcode),
    .id_func3_i(id_func3), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_pc_i(id_pc),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
    .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
    .flush_i(flush), .hold_i(hold),
    .load_use_stall_o(stall), .ex_valid_o(ex_valid),
    .ex_ctrl_o(ex_ctrl), .ex_pc_o(ex_pc),
    .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
    .ex_imm_o(ex_imm), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2),
    .ex_rd_o(ex_rd), .bubble_count_o(cnt)
  );

  id_ex_stage_reg #(.XLEN(32), .CNTW(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_opcode_i(id_opcode),
    .id_func3_i(id_func3), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_pc_i(id_pc),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
    .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
    .flush_i(flush), .hold_i(hold),
    .load_use_stall_o(stall4), .ex_valid_o(ex_valid4),
    .ex_ctrl_o(ex_ctrl4), .ex_pc_o(ex_pc4),
    .ex_rs1_data_o(ex_rs1_data4), .ex_rs2_data_o(ex_rs2_data4),
    .ex_imm_o(ex_imm4), .ex_rs1_o(ex_rs14), .ex_rs2_o(ex_rs24),
    .ex_rd_o(ex_rd4), .bubble_count_o(cnt4)
  );

  function automatic exp_t mk(logic v, logic [18:0] c,
                              logic [4:0] a, logic [4:0] b,
                              logic [4:0] d, logic [31:0] pc,
                              int n);
    exp_t e;
    e.v    = v;
    e.ctrl = v ? c  : 19'd0;
    e.rs1  = v ? a  : 5'd0;
    e.rs2  = v ? b  : 5'd0;
    e.rd   = v ? d  : 5'd0;
    e.pc   = v ? pc : 32'd0;
    e.nb   = n;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic drv(logic [6:0] op, logic [4:0] a, logic [4:0] b,
                     logic [4:0] d, logic [31:0] pc,
                     logic [18:0] c);
    id_valid    = 1'b1;
    id_opcode   = op;
    id_rs1      = a;
    id_rs2      = b;
    id_rd       = d;
    id_pc       = pc;
    id_rs1_data = pc ^ 32'h1111_0000;
    id_rs2_data = pc ^ 32'h2222_0000;
    id_imm      = pc ^ 32'h0000_3333;
    id_ctrl     = c;
    id_func3    = c[2:0];
  endtask

  task automatic stall_is(string tag, logic e);
    #1;
    chk(tag, {31'd0, stall}, {31'd0, e});
    chk({tag, "_4"}, {31'd0, stall4}, {31'd0, e});
  endtask

  task automatic step(exp_t ein);
    exp_t e;
    int   sat;
    sb.push_back(ein);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    sat = (e.nb > 15) ? 15 : e.nb;
    chk("valid", {31'd0, ex_valid}, {31'd0, e.v});
    chk("ctrl", {13'd0, ex_ctrl}, {13'd0, e.ctrl});
    chk("rs1", {27'd0, ex_rs1}, {27'd0, e.rs1});
    chk("rs2", {27'd0, ex_rs2}, {27'd0, e.rs2});
    chk("rd", {27'd0, ex_rd}, {27'd0, e.rd});
    chk("pc", ex_pc, e.pc);
    chk("rs1d", ex_rs1_data, e.v ? e.pc ^ 32'h1111_0000 : 32'd0);
    chk("rs2d", ex_rs2_data, e.v ? e.pc ^ 32'h2222_0000 : 32'd0);
    chk("imm", ex_imm, e.v ? e.pc ^ 32'h0000_3333 : 32'd0);
    chk("count", cnt, e.nb);
    chk("count4", {28'd0, cnt4}, sat);
    chk("valid4", {31'd0, ex_valid4}, {31'd0, e.v});
    chk("rd4", {27'd0, ex_rd4}, {27'd0, e.rd});
  endtask

  task automatic reset_zero(string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_ctrl"}, {13'd0, ex_ctrl}, 32'd0);
    chk({tag, "_pc"}, ex_pc, 32'd0);
    chk({tag, "_rd"}, {27'd0, ex_rd}, 32'd0);
    chk({tag, "_imm"}, ex_imm, 32'd0);
    chk({tag, "_cnt"}, cnt, 32'd0);
    chk({tag, "_cnt4"}, {28'd0, cnt4}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    id_valid = 1'b0; id_opcode = '0; id_func3 = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_pc = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_zero("rst0");
    rst = 1'b0;

    // lw x5,0(x1) ; add x6,x5,x2
    drv(OP_LOAD, 5'd1, 5'd0, 5'd5, 32'h100, CT_LOAD);
    stall_is("lw_nostall", 1'b0);
    step(mk(1, CT_LOAD, 1, 0, 5, 32'h100, nb));
    drv(OP_R, 5'd5, 5'd2, 5'd6, 32'h104, CT_ADD);
    stall_is("lu_stall", 1'b1);
    nb++;
    step(mk(0, 0, 0, 0, 0, 0, nb));
    stall_is("lu_clear", 1'b0);
    step(mk(1, CT_ADD, 5, 2, 6, 32'h104, nb));

    // lw x0 ; add x6,x0,x2
    drv(OP_LOAD, 5'd1, 5'd0, 5'd0, 32'h108, CT_LOAD);
    step(mk(1, CT_LOAD, 1, 0, 0, 32'h108, nb));
    drv(OP_R, 5'd0, 5'd2, 5'd6, 32'h10c, CT_ADD);
    stall_is("x0_nostall", 1'b0);
    step(mk(1, CT_ADD, 0, 2, 6, 32'h10c, nb));

    // lw x5 ; lui x5 (rs1 field aliases x5)
    drv(OP_LOAD, 5'd1, 5'd0, 5'd5, 32'h110, CT_LOAD);
    step(mk(1, CT_LOAD, 1, 0, 5, 32'h110, nb));
    drv(OP_LUI, 5'd5, 5'd5, 5'd5, 32'h114, CT_LUI);
    stall_is("lui_nostall", 1'b0);
    step(mk(1, CT_LUI, 5, 5, 5, 32'h114, nb));

    // lw x7 ; sw x7,0(x3) -> hazard through rs2
    drv(OP_LOAD, 5'd1, 5'd0, 5'd7, 32'h118, CT_LOAD);
    step(mk(1, CT_LOAD, 1, 0, 7, 32'h118, nb));
    drv(OP_STORE, 5'd3, 5'd7, 5'd0, 32'h11c, CT_STORE);
    stall_is("sw_stall", 1'b1);
    nb++;
    step(mk(0, 0, 0, 0, 0, 0, nb));
    step(mk(1, CT_STORE, 3, 7, 0, 32'h11c, nb));

    // lw x8 ; lw x9,0(x8) ; add x10,x9,x9
    drv(OP_LOAD, 5'd1, 5'd0, 5'd8, 32'h120, CT_LOAD);
    step(mk(1, CT_LOAD, 1, 0, 8, 32'h120, nb));
    drv(OP_LOAD, 5'd8, 5'd0, 5'd9, 32'h124, CT_LOAD);
    stall_is("b2b_stall1", 1'b1);
    nb++;
    step(mk(0, 0, 0, 0, 0, 0, nb));
    step(mk(1, CT_LOAD, 8, 0, 9, 32'h124, nb));
    drv(OP_R, 5'd9, 5'd9, 5'd10, 32'h128, CT_ADD);
    stall_is("b2b_stall2", 1'b1);
    nb++;
    step(mk(0, 0, 0, 0, 0, 0, nb));
    step(mk(1, CT_ADD, 9, 9, 10, 32'h128, nb));

    // flush together with hold kills the ID instruction
    drv(OP_LOAD, 5'd1, 5'd0, 5'd5, 32'h12c, CT_LOAD);
    flush = 1'b1;
    hold  = 1'b1;
    stall_is("flush_nostall", 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, nb));
    flush = 1'b0;
    hold  = 1'b0;

    // hold for 3 cycles with a dependent instruction waiting
    drv(OP_LOAD, 5'd1, 5'd0, 5'd5, 32'h130, CT_LOAD);
    step(mk(1, CT_LOAD, 1, 0, 5, 32'h130, nb));
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(OP_R, 5'd5, 5'd2, 5'd6, 32'h134 + 4 * i, CT_ADD);
      stall_is("hold_nostall", 1'b0);
      step(mk(1, CT_LOAD, 1, 0, 5, 32'h130, nb));
    end
    hold = 1'b0;
    drv(OP_R, 5'd5, 5'd2, 5'd6, 32'h140, CT_ADD);
    stall_is("unhold_stall", 1'b1);
    nb++;
    step(mk(0, 0, 0, 0, 0, 0, nb));
    step(mk(1, CT_ADD, 5, 2, 6, 32'h140, nb));

    // drive the 4-bit counter past all-ones
    for (int k = 0; k < 11; k++) begin
      drv(OP_LOAD, 5'd1, 5'd0, 5'd11, 32'h200 + 8 * k, CT_LOAD);
      step(mk(1, CT_LOAD, 1, 0, 11, 32'h200 + 8 * k, nb));
      drv(OP_R, 5'd11, 5'd2, 5'd12, 32'h204 + 8 * k, CT_ADD);
      stall_is("sat_stall", 1'b1);
      nb++;
      step(mk(0, 0, 0, 0, 0, 0, nb));
      step(mk(1, CT_ADD, 11, 2, 12, 32'h204 + 8 * k, nb));
    end
    chk("sat_final4", {28'd0, cnt4}, 32'd15);
    chk("sat_final32", cnt, 32'd16);

    // async reset between edges while a stall is pending
    drv(OP_LOAD, 5'd1, 5'd0, 5'd5, 32'h300, CT_LOAD);
    step(mk(1, CT_LOAD, 1, 0, 5, 32'h300, nb));
    drv(OP_R, 5'd5, 5'd2, 5'd6, 32'h304, CT_ADD);
    stall_is("pre_rst_stall", 1'b1);
    #2;
    rst = 1'b1;
    #1;
    reset_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
